// File: rtl/kv_proto_pkg.sv
// Shared definitions for the key-value command link: frame constants,
// status codes and the UART transmit state encoding.
// Build option: KV_RSP_CHECKSUM_EN appends an XOR checksum byte to each frame.
package kv_proto_pkg;

  localparam logic [7:0]  HDR_BYTE_DEF = 8'hA5;
  localparam int unsigned KEY_W_DEF    = 32;
  localparam int unsigned VAL_W_DEF    = 64;

  localparam logic [7:0] ST_OK       = 8'h00;
  localparam logic [7:0] ST_NOTFOUND = 8'h01;
  localparam logic [7:0] ST_FULL     = 8'h02;
  localparam logic [7:0] ST_BADCMD   = 8'h03;

`ifdef KV_RSP_CHECKSUM_EN
  localparam int unsigned CSUM_BYTES = 1;
`else
  localparam int unsigned CSUM_BYTES = 0;
`endif

  // Bytes per response frame: header, status, key, value and optional checksum.
  function automatic int unsigned kv_frame_bytes(input int unsigned key_w,
                                                 input int unsigned val_w);
    return 2 + key_w / 8 + val_w / 8 + CSUM_BYTES;
  endfunction

  localparam int unsigned NB_DEF = kv_frame_bytes(KEY_W_DEF, VAL_W_DEF);

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser paced by an oversample tick. A new byte is taken from
// byte_data whenever the line leaves IDLE or a STOP bit ends with byte_valid
// still high, so consecutive bytes run with no idle gap.
module uart_tx_byte
  import kv_proto_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_in,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       byte_load_c,
  output logic       byte_done_c,
  output logic       dtx
);

  localparam int unsigned TW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;

  tx_state_e   state_q;
  logic [TW-1:0] tick_cnt_q;
  logic [2:0]  bit_cnt_q;
  logic [7:0]  shreg_q;
  logic        last_tick;

  assign last_tick   = tick_in && (tick_cnt_q == TW'(OVERSAMPLE - 1));
  assign byte_done_c = (state_q == TX_STOP) && last_tick;
  assign byte_load_c = byte_valid &&
                       (((state_q == TX_IDLE) && tick_in) || byte_done_c);

  // Bit-timing FSM: each bit spans OVERSAMPLE ticks, transitions on the last one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= TX_IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      dtx        <= 1'b1;
    end else if (tick_in) begin
      case (state_q)
        TX_IDLE: begin
          tick_cnt_q <= '0;
          if (byte_valid) begin
            state_q   <= TX_START;
            shreg_q   <= byte_data;
            bit_cnt_q <= '0;
            dtx       <= 1'b0;
          end
        end
        TX_START: begin
          if (last_tick) begin
            state_q    <= TX_DATA;
            tick_cnt_q <= '0;
            dtx        <= shreg_q[0];
          end else begin
            tick_cnt_q <= tick_cnt_q + TW'(1);
          end
        end
        TX_DATA: begin
          if (last_tick) begin
            tick_cnt_q <= '0;
            if (bit_cnt_q == 3'd7) begin
              state_q <= TX_STOP;
              dtx     <= 1'b1;
            end else begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
              shreg_q   <= {1'b0, shreg_q[7:1]};
              dtx       <= shreg_q[1];
            end
          end else begin
            tick_cnt_q <= tick_cnt_q + TW'(1);
          end
        end
        TX_STOP: begin
          if (last_tick) begin
            tick_cnt_q <= '0;
            if (byte_valid) begin
              state_q   <= TX_START;
              shreg_q   <= byte_data;
              bit_cnt_q <= '0;
              dtx       <= 1'b0;
            end else begin
              state_q <= TX_IDLE;
            end
          end else begin
            tick_cnt_q <= tick_cnt_q + TW'(1);
          end
        end
        default: begin
          state_q    <= TX_IDLE;
          tick_cnt_q <= '0;
          dtx        <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/kv_rsp_transmitter.sv
// Response transmitter: captures one (status, key, value) response into a
// shadow frame buffer and streams it out as UART bytes, header first.
// Build option: KV_RSP_CHECKSUM_EN appends the XOR of all non-header bytes.
module kv_rsp_transmitter
  import kv_proto_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = 16,
  parameter logic [7:0]  HDR_BYTE   = HDR_BYTE_DEF,
  parameter int unsigned KEY_W      = KEY_W_DEF,
  parameter int unsigned VAL_W      = VAL_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick_in,
  input  logic             rsp_valid,
  output logic             rsp_ready,
  input  logic [7:0]       rsp_status,
  input  logic [KEY_W-1:0] rsp_key,
  input  logic [VAL_W-1:0] rsp_value,
  output logic             dtx,
  output logic             busy
);

  localparam int unsigned NB  = kv_frame_bytes(KEY_W, VAL_W);
  localparam int unsigned FW  = NB * 8;
  localparam int unsigned BCW = $clog2(NB + 1);

  logic [FW-1:0]  frame_q;
  logic [FW-1:0]  frame_d;
  logic [BCW-1:0] byte_cnt_q;
  logic           byte_valid;
  logic           byte_load_c;
  logic           byte_done_c;
  logic           capture;

  assign rsp_ready  = !busy;
  assign capture    = rsp_valid && !busy;
  assign byte_valid = busy && (byte_cnt_q != BCW'(NB));

`ifdef KV_RSP_CHECKSUM_EN
  logic [7:0] csum_c;

  // XOR of status, key and value bytes, formed from the live inputs at capture.
  always_comb begin
    csum_c = rsp_status;
    for (int i = 0; i < int'(KEY_W / 8); i++) csum_c ^= rsp_key[i*8 +: 8];
    for (int i = 0; i < int'(VAL_W / 8); i++) csum_c ^= rsp_value[i*8 +: 8];
  end

  assign frame_d = {HDR_BYTE, rsp_status, rsp_key, rsp_value, csum_c};
`else
  assign frame_d = {HDR_BYTE, rsp_status, rsp_key, rsp_value};
`endif

  // Frame buffer shifts left one byte per load, so the next byte is always on top.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_q    <= '0;
      byte_cnt_q <= '0;
      busy       <= 1'b0;
    end else if (capture) begin
      frame_q    <= frame_d;
      byte_cnt_q <= '0;
      busy       <= 1'b1;
    end else begin
      if (byte_load_c) begin
        frame_q    <= {frame_q[FW-9:0], 8'h00};
        byte_cnt_q <= byte_cnt_q + BCW'(1);
      end
      if (byte_done_c && (byte_cnt_q == BCW'(NB))) busy <= 1'b0;
    end
  end

  uart_tx_byte #(
    .OVERSAMPLE (OVERSAMPLE)
  ) u_tx (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick_in     (tick_in),
    .byte_valid  (byte_valid),
    .byte_data   (frame_q[FW-1 -: 8]),
    .byte_load_c (byte_load_c),
    .byte_done_c (byte_done_c),
    .dtx         (dtx)
  );

endmodule
